// File: rtl/tick_scheduler_pkg.sv
// Shared types and default sizing for the tick scheduler.
package tick_scheduler_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int CHANNELS_DEF = 4;
  localparam int SEL_W_DEF    = 5;
  localparam int CH_W_DEF     = 2;

  // Per-channel FSM encoding; 2'd3 is unreachable and recovers to OFF.
  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tick_scheduler_channel.sv
// One tick channel: watches a single divider tap and emits a 1-cycle
// enable on each rising edge of that tap. ARM waits for the tap to read 0
// before RUN, so a retune never produces a spurious edge.
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk_src,
  input  logic             rst,
  input  logic [WIDTH-1:0] clk_group,
  input  logic             load,
  input  logic             load_en,
  input  logic [SEL_W-1:0] load_tap,
  output logic             tick,
  output logic             active,
  output logic             arming
);

  ch_state_e        state_q, state_d;
  logic [SEL_W-1:0] tap_q, tap_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic             b;

  // Tap sample; a mask-and-reduce keeps every tap bit in use and reads 0
  // for an out-of-range index (never latched, but harmless if it were).
  assign b = |(clk_group & (WIDTH'(1) << tap_q));

  // State, tap, edge history and tick registers.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state_q <= ST_OFF;
      tap_q   <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
    end
  end

  // Next state; an accepted load overrides everything, including an edge
  // that would have ticked this cycle.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    prev_d  = prev_q;
    tick_d  = 1'b0;
    if (load) begin
      state_d = load_en ? ST_ARM : ST_OFF;
      if (load_en) tap_d = load_tap;
      prev_d  = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_OFF;
        ST_ARM: begin
          if (!b) begin
            state_d = ST_RUN;
            prev_d  = 1'b0;
          end
        end
        ST_RUN: begin
          prev_d = b;
          tick_d = b & ~prev_q;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign tick   = tick_q;
  assign active = (state_q == ST_RUN);
  assign arming = (state_q == ST_ARM);

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler top: decodes config requests, range-checks them, and
// fans loads out to an array of tick channels. Only one channel may be
// arming at a time, which is what holds cfg_ready low.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int CH_W     = CH_W_DEF
) (
  input  logic                clk_src,
  input  logic                rst,
  input  logic [WIDTH-1:0]    clk_group,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [SEL_W-1:0]    cfg_tap,
  input  logic                cfg_enable,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active
);

  logic                accept;
  logic                chan_ok;
  logic                tap_ok;
  logic                load_en;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] arming;

  assign cfg_ready = ~|arming;
  assign accept    = cfg_valid & cfg_ready;
  assign chan_ok   = 32'(cfg_chan) < 32'(CHANNELS);
  assign tap_ok    = 32'(cfg_tap) < 32'(WIDTH);
  // An enable with a bad tap degrades to a stop of the target channel.
  assign load_en   = cfg_enable & tap_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load[i] = accept & chan_ok & (cfg_chan == CH_W'(i));

    tick_channel #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
    ) u_ch (
      .clk_src   (clk_src),
      .rst       (rst),
      .clk_group (clk_group),
      .load      (load[i]),
      .load_en   (load_en),
      .load_tap  (cfg_tap),
      .tick      (tick[i]),
      .active    (active[i]),
      .arming    (arming[i])
    );
  end

  // Error pulse for one cycle after accepting a bad channel or bad tap.
  always_ff @(posedge clk_src) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= accept & (~chan_ok | (cfg_enable & ~tap_ok));
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler; clk_group is a free-running counter.
module tb_tick_scheduler;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 6;
  localparam int CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [WIDTH-1:0]    cnt = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_chan = '0;
  logic [SEL_W-1:0]    cfg_tap = '0;
  logic                cfg_enable = 1'b0;
  logic                cfg_err;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] active;

  int n_tests = 0;
  int n_fail  = 0;

  tick_scheduler #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .CH_W(CH_W)
  ) dut (
    .clk_src   (clk),
    .rst       (rst),
    .clk_group (cnt),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_tap   (cfg_tap),
    .cfg_enable(cfg_enable),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .active    (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1'b1;

  // After return, registered outputs reflect the last edge and cnt is the
  // value the next edge will sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++; if (tick !== 4'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0000", tick); end
    n_tests++; if (active !== 4'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0000", active); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", cfg_err); end
    rst = 1'b0;
    step();
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_ch0_tap0();
    logic [WIDTH-1:0] s;
    int g = 0;
    while (cnt[0] !== 1'b1 && g < 4) begin step(); g++; end
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_tap = 6'd0; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ch0_arm_ready got %b exp 0", cfg_ready); end
    n_tests++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL ch0_arm_active got %b exp 0", active[0]); end
    step();
    n_tests++; if (active[0] !== 1'b1) begin n_fail++; $display("FAIL ch0_run_active got %b exp 1", active[0]); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ch0_run_ready got %b exp 1", cfg_ready); end
    n_tests++; if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL ch0_run_tick got %b exp 0", tick[0]); end
    for (int k = 0; k < 10; k++) begin
      s = cnt;
      step();
      n_tests++; if (tick[0] !== s[0]) begin n_fail++; $display("FAIL ch0_period k=%0d got %b exp %b", k, tick[0], s[0]); end
    end
  endtask

  task automatic test_ch1_tap3();
    logic [WIDTH-1:0] s;
    int g = 0;
    int pulses = 0;
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ch1_pre_ready got %b exp 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_tap = 6'd3; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    while (active[1] !== 1'b1 && g < 20) begin step(); g++; end
    n_tests++; if (active[1] !== 1'b1) begin n_fail++; $display("FAIL ch1_run_timeout got %b exp 1", active[1]); end
    for (int k = 0; k < 48; k++) begin
      s = cnt;
      step();
      if (tick[1] === 1'b1) pulses++;
      n_tests++; if (tick[1] !== (s[3:0] == 4'd8)) begin n_fail++; $display("FAIL ch1_tick s=%0d got %b exp %b", s, tick[1], (s[3:0] == 4'd8)); end
      n_tests++; if (tick[0] !== s[0]) begin n_fail++; $display("FAIL ch1_ch0_tick s=%0d got %b exp %b", s, tick[0], s[0]); end
    end
    n_tests++; if (pulses !== 3) begin n_fail++; $display("FAIL ch1_pulses got %0d exp 3", pulses); end
  endtask

  task automatic test_retune_stall();
    logic [WIDTH-1:0] s;
    int g = 0;
    int pulses = 0;
    while (cnt[5:0] !== 6'd32 && g < 70) begin step(); g++; end
    n_tests++; if (cnt[5:0] !== 6'd32) begin n_fail++; $display("FAIL retune_wait got %0d exp 32", cnt[5:0]); end
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_tap = 6'd5; cfg_enable = 1'b1;
    step();
    // ch2 request presented right away; must stall through ch1's ARM
    cfg_chan = 2'd2; cfg_tap = 6'd2; cfg_enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n_tests++; if (cfg_ready !== 1'b0 || tick[1] !== 1'b0 || active[2] !== 1'b0 || active[1] !== 1'b0)
        begin n_fail++; $display("FAIL retune_arm k=%0d ready=%b tick1=%b act=%b exp 0/0/x0x0", k, cfg_ready, tick[1], active); end
      step();
    end
    n_tests++; if (cfg_ready !== 1'b1 || active[1] !== 1'b1 || active[2] !== 1'b0)
      begin n_fail++; $display("FAIL retune_run ready=%b act=%b exp 1/x01x", cfg_ready, active); end
    step();
    cfg_valid = 1'b0;
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ch2_accept_ready got %b exp 0", cfg_ready); end
    for (int k = 0; k < 40; k++) begin
      s = cnt;
      step();
      if (tick[1] === 1'b1) pulses++;
      n_tests++; if (tick[1] !== (s[5:0] == 6'd32)) begin n_fail++; $display("FAIL retune_tick s=%0d got %b exp %b", s, tick[1], (s[5:0] == 6'd32)); end
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL retune_pulses got %0d exp 1", pulses); end
    n_tests++; if (active[2] !== 1'b1) begin n_fail++; $display("FAIL ch2_active got %b exp 1", active[2]); end
  endtask

  task automatic test_illegal_tap();
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_tap = 6'd40; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", cfg_err); end
    n_tests++; if (active[2] !== 1'b0) begin n_fail++; $display("FAIL illegal_active2 got %b exp 0", active[2]); end
    n_tests++; if (tick[2] !== 1'b0) begin n_fail++; $display("FAIL illegal_tick2 got %b exp 0", tick[2]); end
    n_tests++; if (active[1:0] !== 2'b11) begin n_fail++; $display("FAIL illegal_others got %b exp 11", active[1:0]); end
    step();
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_len got %b exp 0", cfg_err); end
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (tick[2] !== 1'b0 || active[2] !== 1'b0) begin n_fail++; $display("FAIL illegal_quiet k=%0d tick2=%b act2=%b exp 0/0", k, tick[2], active[2]); end
    end
  endtask

  task automatic test_reset_midrun();
    n_tests++; if (active[1:0] !== 2'b11) begin n_fail++; $display("FAIL midrun_pre got %b exp 11", active[1:0]); end
    // same-cycle accept must lose to reset
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_tap = 6'd0; cfg_enable = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0; cfg_valid = 1'b0;
    n_tests++; if (tick !== 4'b0 || active !== 4'b0) begin n_fail++; $display("FAIL midrun_clear tick=%b act=%b exp 0000/0000", tick, active); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready got %b exp 1", cfg_ready); end
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++; if (tick !== 4'b0 || active !== 4'b0) begin n_fail++; $display("FAIL midrun_quiet k=%0d tick=%b act=%b exp 0000/0000", k, tick, active); end
    end
  endtask

  task automatic test_stop_on_edge();
    int g = 0;
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_tap = 6'd0; cfg_enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    while (active[0] !== 1'b1 && g < 8) begin step(); g++; end
    g = 0;
    while (cnt[0] !== 1'b1 && g < 4) begin step(); g++; end
    n_tests++; if (active[0] !== 1'b1 || cnt[0] !== 1'b1) begin n_fail++; $display("FAIL stop_setup act0=%b bit0=%b exp 1/1", active[0], cnt[0]); end
    // the edge sampled this cycle would tick; the stop must suppress it
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_enable = 1'b0;
    step();
    cfg_valid = 1'b0;
    n_tests++; if (tick[0] !== 1'b0 || active[0] !== 1'b0) begin n_fail++; $display("FAIL stop_forced tick0=%b act0=%b exp 0/0", tick[0], active[0]); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL stop_err got %b exp 0", cfg_err); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++; if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL stop_quiet k=%0d got %b exp 0", k, tick[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_ch0_tap0();
    test_ch1_tap3();
    test_retune_stall();
    test_illegal_tap();
    test_reset_midrun();
    test_stop_on_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
